user_verify: RTL

USER_VERIFY -- requirements
Module: user_verify

---
 rtl/user_verify_if.sv | 51 +++++
 rtl/user_verify.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/user_verify_if.sv
// -----------------------------------------------------------------------------
// user_verify_if
//   Bundle of the ID-check request, table-programming and status signals
//   used by user_verify. Clock and reset are not part of the bundle.
//
//   Request side (driven by master):
//     id_valid   level, high while id_in holds a complete 16-bit ID
//     id_in      user ID to check
//     retry      one-cycle pulse that releases a grant
//     prog_we    table write strobe
//     prog_addr  table entry index
//     prog_data  ID to store
//     prog_clr   with prog_we: invalidate the addressed entry instead
//   Status side (driven by slave):
//     busy       high whenever the checker is not idle
//     auth_ok    high while access is granted
//     auth_fail  one-cycle pulse per denial
//     locked     high during lockout
//     user_index matched table entry, valid while auth_ok
//     fail_count consecutive-denial count
// -----------------------------------------------------------------------------
interface user_verify_if #(
  parameter int NUM_USERS = 8
);
  localparam int IW = $clog2(NUM_USERS);

  logic          id_valid;
  logic [15:0]   id_in;
  logic          retry;
  logic          prog_we;
  logic [IW-1:0] prog_addr;
  logic [15:0]   prog_data;
  logic          prog_clr;

  logic          busy;
  logic          auth_ok;
  logic          auth_fail;
  logic          locked;
  logic [IW-1:0] user_index;
  logic [2:0]    fail_count;

  modport master (
    output id_valid, id_in, retry, prog_we, prog_addr, prog_data, prog_clr,
    input  busy, auth_ok, auth_fail, locked, user_index, fail_count
  );

  modport slave (
    input  id_valid, id_in, retry, prog_we, prog_addr, prog_data, prog_clr,
    output busy, auth_ok, auth_fail, locked, user_index, fail_count
  );
endinterface

// File: rtl/user_verify.sv
// -----------------------------------------------------------------------------
// user_verify
//   Checks a 16-bit user ID against a programmable table of NUM_USERS entries.
//   A rising edge of id_valid in IDLE captures id_in and starts a linear search,
//   one entry per cycle from index 0. The first valid entry holding the
//   captured ID wins and the block holds GRANT until retry. A miss on every
//   entry produces a one-cycle DENY; MAX_FAIL consecutive denials put the block
//   into LOCK for LOCK_CYCLES cycles, during which new requests are ignored.
//
//   Ports:
//     clk  clock, all state changes on its rising edge
//     rst  synchronous, active-low reset
//     bus  user_verify_if.slave (request, programming and status signals)
//
//   Parameters:
//     NUM_USERS   table entries, power of two, 2..16
//     MAX_FAIL    consecutive denials that trigger lockout, 1..7
//     LOCK_CYCLES lockout duration in clk cycles, >= 1
// -----------------------------------------------------------------------------
module user_verify #(
  parameter int NUM_USERS   = 8,
  parameter int MAX_FAIL    = 3,
  parameter int LOCK_CYCLES = 1000
) (
  input  logic           clk,
  input  logic           rst,
  user_verify_if.slave   bus
);

  localparam int IW = $clog2(NUM_USERS);
  localparam int CW = $clog2(LOCK_CYCLES + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SEARCH = 3'd1;
  localparam logic [2:0] S_GRANT  = 3'd2;
  localparam logic [2:0] S_DENY   = 3'd3;
  localparam logic [2:0] S_LOCK   = 3'd4;

  localparam logic [IW-1:0] LAST_IDX   = IW'(NUM_USERS - 1);
  localparam logic [CW-1:0] LOCK_LAST  = CW'(LOCK_CYCLES - 1);
  localparam logic [2:0]    FAIL_LIMIT = 3'(MAX_FAIL);

  // FSM and request capture
  logic [2:0]    state_q,    state_d;
  logic          id_prev_q;
  logic [15:0]   cap_id_q,   cap_id_d;

  // Search pipeline: cmp_idx_q is the next entry to compare; the result of
  // the previous compare sits in hit_q/res_idx_q/last_q, qualified by cmp_vld_q.
  logic [IW-1:0] cmp_idx_q,  cmp_idx_d;
  logic          cmp_vld_q,  cmp_vld_d;
  logic          hit_q,      hit_d;
  logic          last_q,     last_d;
  logic [IW-1:0] res_idx_q,  res_idx_d;

  // Result and lockout bookkeeping
  logic [IW-1:0] user_idx_q, user_idx_d;
  logic [2:0]    fail_cnt_q, fail_cnt_d;
  logic [CW-1:0] lock_cnt_q, lock_cnt_d;

  // User table
  logic [NUM_USERS-1:0] tbl_vld_q;
  logic [15:0]          tbl_id_q [NUM_USERS];

  logic id_rise;
  logic tbl_we;
  logic entry_match;

  // The history register makes a level that stays high across GRANT or LOCK
  // look like "no edge", so only a fresh rise starts a search.
  assign id_rise     = bus.id_valid & ~id_prev_q;
  assign tbl_we      = rst && (state_q == S_IDLE) && bus.prog_we;
  assign entry_match = tbl_vld_q[cmp_idx_q] && (tbl_id_q[cmp_idx_q] == cap_id_q);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    cap_id_d   = cap_id_q;
    cmp_idx_d  = cmp_idx_q;
    cmp_vld_d  = cmp_vld_q;
    hit_d      = hit_q;
    last_d     = last_q;
    res_idx_d  = res_idx_q;
    user_idx_d = user_idx_q;
    fail_cnt_d = fail_cnt_q;
    lock_cnt_d = lock_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (id_rise) begin
          state_d   = S_SEARCH;
          cap_id_d  = bus.id_in;
          cmp_idx_d = '0;
          cmp_vld_d = 1'b0;
        end
      end

      S_SEARCH: begin
        if (cmp_vld_q && hit_q) begin
          state_d    = S_GRANT;
          user_idx_d = res_idx_q;
          fail_cnt_d = 3'd0;
        end else if (cmp_vld_q && last_q) begin
          state_d    = S_DENY;
          fail_cnt_d = fail_cnt_q + 3'd1;
        end else begin
          // Register the compare of one entry and step to the next. Index
          // wrap after the last entry is harmless: the registered last_q
          // ends the search on the following cycle.
          cmp_vld_d = 1'b1;
          hit_d     = entry_match;
          last_d    = (cmp_idx_q == LAST_IDX);
          res_idx_d = cmp_idx_q;
          cmp_idx_d = cmp_idx_q + 1'b1;
        end
      end

      S_GRANT: begin
        if (bus.retry) begin
          state_d = S_IDLE;
        end
      end

      S_DENY: begin
        // fail_cnt_q already holds the incremented count here.
        if (fail_cnt_q == FAIL_LIMIT) begin
          state_d    = S_LOCK;
          lock_cnt_d = '0;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_LOCK: begin
        if (lock_cnt_q == LOCK_LAST) begin
          state_d    = S_IDLE;
          fail_cnt_d = 3'd0;
          lock_cnt_d = '0;
        end else begin
          lock_cnt_d = lock_cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      id_prev_q  <= 1'b0;
      cap_id_q   <= '0;
      cmp_idx_q  <= '0;
      cmp_vld_q  <= 1'b0;
      hit_q      <= 1'b0;
      last_q     <= 1'b0;
      res_idx_q  <= '0;
      user_idx_q <= '0;
      fail_cnt_q <= 3'd0;
      lock_cnt_q <= '0;
      tbl_vld_q  <= '0;
    end else begin
      state_q    <= state_d;
      id_prev_q  <= bus.id_valid;
      cap_id_q   <= cap_id_d;
      cmp_idx_q  <= cmp_idx_d;
      cmp_vld_q  <= cmp_vld_d;
      hit_q      <= hit_d;
      last_q     <= last_d;
      res_idx_q  <= res_idx_d;
      user_idx_q <= user_idx_d;
      fail_cnt_q <= fail_cnt_d;
      lock_cnt_q <= lock_cnt_d;
      if (tbl_we) begin
        tbl_vld_q[bus.prog_addr] <= ~bus.prog_clr;
      end
    end
  end

  // NOTE: only the valid bits are reset; the stored IDs are never observed
  // without a set valid bit, so the ID array is left without reset and can map
  // onto plain storage.
  always_ff @(posedge clk) begin
    if (tbl_we && !bus.prog_clr) begin
      tbl_id_q[bus.prog_addr] <= bus.prog_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.auth_ok    = (state_q == S_GRANT);
  assign bus.auth_fail  = (state_q == S_DENY);
  assign bus.locked     = (state_q == S_LOCK);
  assign bus.user_index = (state_q == S_GRANT) ? user_idx_q : '0;
  assign bus.fail_count = fail_cnt_q;

endmodule
